// File: rtl/cv32e40px_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40px_req_sequencer
// Purpose  : Latches per-line request pulses and offers the lowest eligible
//            pending index to a valid/ready consumer.
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40px_req_sequencer #(
    parameter int LEN = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [LEN-1:0]           req_i,
    input  logic [LEN-1:0]           mask_i,
    input  logic                     clear_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [$clog2(LEN)-1:0]   id_o,
    output logic [LEN-1:0]           pending_o,
    output logic [$clog2(LEN+1)-1:0] count_o,
    output logic                     overflow_o
);

    localparam int c_ID_W  = $clog2(LEN);
    localparam int c_CNT_W = $clog2(LEN+1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_valid;
    logic [c_ID_W-1:0]   r_id;
    logic [LEN-1:0]      r_pending;
    logic                r_overflow;

    logic                w_hs;
    logic [LEN-1:0]      w_id_onehot;
    logic [LEN-1:0]      w_hs_mask;
    logic [LEN-1:0]      w_elig;
    logic [LEN-1:0]      w_pending_nxt;
    logic                w_ovf;
    logic                w_cand_vld;
    logic [c_ID_W-1:0]   w_cand_id;
    logic [c_CNT_W-1:0]  w_count;

    assign w_hs        = r_valid & ready_i;
    assign w_id_onehot = {{(LEN-1){1'b0}}, 1'b1} << r_id;
    assign w_hs_mask   = w_hs ? w_id_onehot : '0;

    // The line being consumed this edge is excluded so the next offer never repeats it.
    assign w_elig = r_pending & mask_i & ~w_hs_mask;

    // A new request on the consumed line wins over the handshake clear, so it is re-pended.
    assign w_pending_nxt = clear_i ? '0 : ((r_pending & ~w_hs_mask) | req_i);

    assign w_ovf = ~clear_i & (|(req_i & r_pending & ~w_hs_mask));

    always_comb begin
        w_cand_vld = 1'b0;
        w_cand_id  = '0;
        for (int i = LEN-1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_cand_vld = 1'b1;
                w_cand_id  = c_ID_W'(i);
            end
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < LEN; i++) begin
            w_count = w_count + c_CNT_W'(r_pending[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_valid    <= 1'b0;
            r_id       <= '0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_overflow <= w_ovf;
            case (r_state)
                S_IDLE: begin
                    if (!clear_i && w_cand_vld) begin
                        r_state <= S_OFFER;
                        r_valid <= 1'b1;
                        r_id    <= w_cand_id;
                    end
                end
                S_OFFER: begin
                    if (clear_i) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end else if (w_hs) begin
                        if (w_cand_vld) begin
                            r_id <= w_cand_id;
                        end else begin
                            r_state <= S_IDLE;
                            r_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign valid_o    = r_valid;
    assign id_o       = r_id;
    assign pending_o  = r_pending;
    assign count_o    = w_count;
    assign overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40px_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40px_req_sequencer
// Purpose  : Directed self-checking bench for cv32e40px_req_sequencer (LEN=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cv32e40px_req_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] req_i;
    logic [31:0] mask_i;
    logic        clear_i;
    logic        ready_i;
    logic        valid_o;
    logic [4:0]  id_o;
    logic [31:0] pending_o;
    logic [5:0]  count_o;
    logic        overflow_o;

    int total = 0;
    int bad   = 0;

    cv32e40px_req_sequencer #(.LEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .mask_i    (mask_i),
        .clear_i   (clear_i),
        .ready_i   (ready_i),
        .valid_o   (valid_o),
        .id_o      (id_o),
        .pending_o (pending_o),
        .count_o   (count_o),
        .overflow_o(overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_i = '0; mask_i = '1; clear_i = 1'b0; ready_i = 1'b0;
        #1;
        if (valid_o !== 1'b0 || id_o !== 5'd0 || pending_o !== 32'h0 || count_o !== 6'd0 || overflow_o !== 1'b0) begin
            $display("FAIL reset_state: valid=%b id=%0d pend=%h cnt=%0d ovf=%b exp 0/0/0/0/0", valid_o, id_o, pending_o, count_o, overflow_o);
            bad++;
        end
        total++;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        if (valid_o !== 1'b0 || pending_o !== 32'h0) begin
            $display("FAIL first_idle: valid=%b pend=%h exp 0/0", valid_o, pending_o);
            bad++;
        end
        total++;
    endtask

    task automatic test_basic();
        ready_i = 1'b1; req_i = 32'h0000_0014;
        tick();
        req_i = '0;
        if (valid_o !== 1'b0 || pending_o !== 32'h14 || count_o !== 6'd2) begin
            $display("FAIL basic_pend: valid=%b pend=%h cnt=%0d exp 0/14/2", valid_o, pending_o, count_o);
            bad++;
        end
        total++;
        tick();
        if (valid_o !== 1'b1 || id_o !== 5'd2 || count_o !== 6'd2) begin
            $display("FAIL basic_id2: valid=%b id=%0d cnt=%0d exp 1/2/2", valid_o, id_o, count_o);
            bad++;
        end
        total++;
        tick();
        if (valid_o !== 1'b1 || id_o !== 5'd4 || count_o !== 6'd1) begin
            $display("FAIL basic_id4: valid=%b id=%0d cnt=%0d exp 1/4/1", valid_o, id_o, count_o);
            bad++;
        end
        total++;
        tick();
        if (valid_o !== 1'b0 || count_o !== 6'd0) begin
            $display("FAIL basic_idle: valid=%b cnt=%0d exp 0/0", valid_o, count_o);
            bad++;
        end
        total++;
        ready_i = 1'b0;
    endtask

    task automatic test_hold();
        req_i = 32'h0000_0020;
        tick();
        req_i = '0;
        tick();
        if (valid_o !== 1'b1 || id_o !== 5'd5) begin
            $display("FAIL hold_offer: valid=%b id=%0d exp 1/5", valid_o, id_o);
            bad++;
        end
        total++;
        req_i = 32'h0000_0002;
        tick();
        req_i = '0;
        mask_i = ~32'h0000_0020;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (valid_o !== 1'b1 || id_o !== 5'd5 || pending_o !== 32'h22) begin
                $display("FAIL hold_stable: cyc=%0d valid=%b id=%0d pend=%h exp 1/5/22", i, valid_o, id_o, pending_o);
                bad++;
            end
            total++;
        end
        mask_i = '1; ready_i = 1'b1;
        tick();
        if (valid_o !== 1'b1 || id_o !== 5'd1 || count_o !== 6'd1) begin
            $display("FAIL hold_next: valid=%b id=%0d cnt=%0d exp 1/1/1", valid_o, id_o, count_o);
            bad++;
        end
        total++;
        tick();
        if (valid_o !== 1'b0 || count_o !== 6'd0) begin
            $display("FAIL hold_drain: valid=%b cnt=%0d exp 0/0", valid_o, count_o);
            bad++;
        end
        total++;
        ready_i = 1'b0;
    endtask

    task automatic test_rehandshake();
        req_i = 32'h0000_0008;
        tick();
        req_i = '0;
        tick();
        ready_i = 1'b1; req_i = 32'h0000_0008;
        tick();
        ready_i = 1'b0; req_i = '0;
        if (pending_o !== 32'h8 || overflow_o !== 1'b0 || valid_o !== 1'b0) begin
            $display("FAIL repend: pend=%h ovf=%b valid=%b exp 8/0/0", pending_o, overflow_o, valid_o);
            bad++;
        end
        total++;
        tick();
        if (valid_o !== 1'b1 || id_o !== 5'd3) begin
            $display("FAIL reoffer: valid=%b id=%0d exp 1/3", valid_o, id_o);
            bad++;
        end
        total++;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        if (valid_o !== 1'b0 || pending_o !== 32'h0) begin
            $display("FAIL repend_drain: valid=%b pend=%h exp 0/0", valid_o, pending_o);
            bad++;
        end
        total++;
    endtask

    task automatic test_overflow();
        req_i = 32'h0000_0080;
        tick();
        req_i = '0;
        tick();
        req_i = 32'h0000_0080;
        tick();
        req_i = '0;
        if (overflow_o !== 1'b1 || count_o !== 6'd1 || valid_o !== 1'b1 || id_o !== 5'd7) begin
            $display("FAIL ovf_pulse: ovf=%b cnt=%0d valid=%b id=%0d exp 1/1/1/7", overflow_o, count_o, valid_o, id_o);
            bad++;
        end
        total++;
        tick();
        if (overflow_o !== 1'b0 || count_o !== 6'd1) begin
            $display("FAIL ovf_one_cycle: ovf=%b cnt=%0d exp 0/1", overflow_o, count_o);
            bad++;
        end
        total++;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    task automatic test_mask();
        mask_i = 32'hFFFF_FFF0; req_i = 32'h0000_0003;
        tick();
        req_i = '0;
        tick();
        tick();
        if (valid_o !== 1'b0 || count_o !== 6'd2 || id_o !== 5'd7) begin
            $display("FAIL mask_block: valid=%b cnt=%0d id=%0d exp 0/2/7", valid_o, count_o, id_o);
            bad++;
        end
        total++;
        mask_i = '1;
        tick();
        if (valid_o !== 1'b1 || id_o !== 5'd0) begin
            $display("FAIL mask_open: valid=%b id=%0d exp 1/0", valid_o, id_o);
            bad++;
        end
        total++;
        ready_i = 1'b1;
        tick(); tick();
        ready_i = 1'b0;
        if (valid_o !== 1'b0 || count_o !== 6'd0) begin
            $display("FAIL mask_drain: valid=%b cnt=%0d exp 0/0", valid_o, count_o);
            bad++;
        end
        total++;
    endtask

    task automatic test_back_to_back();
        ready_i = 1'b1; req_i = 32'h0000_00F0;
        tick();
        req_i = '0;
        for (int n = 4; n < 8; n++) begin
            tick();
            if (valid_o !== 1'b1 || id_o !== 5'(n) || count_o !== 6'(8 - n)) begin
                $display("FAIL b2b: valid=%b id=%0d cnt=%0d exp 1/%0d/%0d", valid_o, id_o, count_o, n, 8 - n);
                bad++;
            end
            total++;
        end
        tick();
        ready_i = 1'b0;
        if (valid_o !== 1'b0) begin
            $display("FAIL b2b_end: valid=%b exp 0", valid_o);
            bad++;
        end
        total++;
    endtask

    task automatic test_boundary();
        req_i = 32'h8000_0000;
        tick();
        req_i = '0;
        tick();
        if (valid_o !== 1'b1 || id_o !== 5'd31) begin
            $display("FAIL top_line: valid=%b id=%0d exp 1/31", valid_o, id_o);
            bad++;
        end
        total++;
        req_i = 32'h7FFF_FFFF;
        tick();
        req_i = '0;
        if (count_o !== 6'd32 || pending_o !== 32'hFFFF_FFFF || overflow_o !== 1'b0) begin
            $display("FAIL full_count: cnt=%0d pend=%h ovf=%b exp 32/ffffffff/0", count_o, pending_o, overflow_o);
            bad++;
        end
        total++;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    task automatic test_clear();
        req_i = 32'h0000_001F;
        tick();
        req_i = '0;
        tick();
        clear_i = 1'b1; ready_i = 1'b1; req_i = 32'h0000_0100;
        tick();
        clear_i = 1'b0; ready_i = 1'b0; req_i = '0;
        if (valid_o !== 1'b0 || pending_o !== 32'h0 || count_o !== 6'd0 || overflow_o !== 1'b0) begin
            $display("FAIL clear_flush: valid=%b pend=%h cnt=%0d ovf=%b exp 0/0/0/0", valid_o, pending_o, count_o, overflow_o);
            bad++;
        end
        total++;
        tick();
        if (valid_o !== 1'b0) begin
            $display("FAIL clear_after: valid=%b exp 0", valid_o);
            bad++;
        end
        total++;
        req_i = 32'h0000_001F;
        tick();
        req_i = '0;
        tick();
        #2;
        rst_n = 1'b0; req_i = 32'h0000_0100;
        #1;
        if (valid_o !== 1'b0 || pending_o !== 32'h0 || count_o !== 6'd0 || id_o !== 5'd0) begin
            $display("FAIL async_reset: valid=%b pend=%h cnt=%0d id=%0d exp 0/0/0/0", valid_o, pending_o, count_o, id_o);
            bad++;
        end
        total++;
        tick();
        rst_n = 1'b1; req_i = '0;
        tick();
        if (valid_o !== 1'b0 || pending_o !== 32'h0) begin
            $display("FAIL reset_release: valid=%b pend=%h exp 0/0", valid_o, pending_o);
            bad++;
        end
        total++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_rehandshake();
        test_overflow();
        test_mask();
        test_back_to_back();
        test_boundary();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cv32e40px_req_sequencer.md
CV32E40PX_REQ_SEQUENCER -- requirements
Module: cv32e40px_req_sequencer

Interface
REQ-001: Parameter LEN, default 32, number of request lines; the block SHALL support any LEN >= 2.
REQ-002: clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003: rst_n  input  1  asynchronous, active-low reset.
REQ-004: req_i  input  LEN  per-line request pulses; a bit high at a rising edge SHALL count as one event.
REQ-005: mask_i  input  LEN  per-line enable; only pending lines with mask_i=1 SHALL be eligible for selection.
REQ-006: clear_i  input  1  synchronous flush of all pending state and of any current offer.
REQ-007: valid_o  output  1  an offered index is present on id_o.
REQ-008: ready_i  input  1  consumer accepts; a handshake SHALL occur on a rising edge where valid_o=1 and ready_i=1.
REQ-009: id_o  output  $clog2(LEN)  offered line index; registered.
REQ-010: pending_o  output  LEN  current pending register (pending_q).
REQ-011: count_o  output  $clog2(LEN+1)  population count of pending_q; combinational from pending_q.
REQ-012: overflow_o  output  1  registered one-cycle pulse flagging a lost (merged) request.

Function
REQ-013: Pending update per edge, in priority order: clear_i=1 clears all bits, and same-cycle req_i is discarded. Otherwise a set bit req_i[n] SHALL set pending_q[n]. Otherwise a handshake SHALL clear pending_q[id_o]. All other bits SHALL hold.
REQ-014: If req_i[id_o]=1 in the same cycle as a handshake on id_o, pending_q[id_o] SHALL remain 1: the new event is re-pended and is not lost.
REQ-015: Candidate = lowest index n with pending_q[n]=1, mask_i[n]=1 and, when a handshake occurs this cycle, n != id_o; "none" if no such n (find-first-one semantics, index 0 highest priority).
REQ-016: FSM states IDLE (valid_o=0) and OFFER (valid_o=1).
REQ-017: IDLE -> OFFER when clear_i=0 and a candidate exists; id_o SHALL load the candidate on that edge.
REQ-018: OFFER with no handshake: valid_o and id_o SHALL stay stable, even if mask_i[id_o] drops; an offer SHALL NOT be retracted except by clear_i.
REQ-019: OFFER with handshake: if a candidate exists, stay in OFFER and load id_o with it (back-to-back, no bubble); else go to IDLE.
REQ-020: clear_i=1 in any state SHALL force IDLE on the next edge; a simultaneous handshake SHALL still be counted by the consumer, but the pending bit is cleared by REQ-013 regardless.
REQ-021: Latency: req_i[n] sampled at edge k with the block idle and n eligible -> pending_q[n]=1 after edge k -> valid_o=1, id_o=n after edge k+1.
REQ-022: Throughput: one handshake per cycle sustained while eligible pending bits remain.
REQ-023: overflow_o SHALL pulse high for exactly the cycle after any edge at which req_i[n]=1 and pending_q[n]=1, excluding the REQ-014 case and cycles with clear_i=1.
REQ-024: count_o SHALL equal the number of ones in pending_q at all times; for LEN=32 it reaches 32 without wrap.
REQ-025: When pending_q & mask_i = 0, the block SHALL remain in IDLE with no x-propagation on id_o, which holds its last value.

Reset
REQ-026: On rst_n=0, asynchronously: pending_q=0, state=IDLE, valid_o=0, id_o=0, overflow_o=0, count_o=0.
REQ-027: After rst_n deasserts, the first edge SHALL behave as a normal IDLE cycle.
REQ-028: Assertion of rst_n mid-offer SHALL drop valid_o immediately, without waiting for a clock edge.

Verification
REQ-029: LEN=32, mask all ones, ready_i=1, pulse req_i=0x0000_0014 for one cycle -> id_o=2 with valid_o two edges later, then id_o=4 on the next cycle, then IDLE; count_o goes 2->1->0.
REQ-030: Offer on id 5 with ready_i=0 for 4 cycles while req_i[1] pulses -> id_o stays 5 with valid_o held; after the handshake, id_o=1.
REQ-031: Handshake on id 3 with req_i[3]=1 in the same cycle -> pending_q[3] stays 1, overflow_o=0, and id 3 is re-offered.
REQ-032: pending_q[7]=1, req_i[7] pulses again with no handshake -> overflow_o high for one cycle, count_o unchanged.
REQ-033: mask_i=0xFFFF_FFF0 with req_i=0x0000_0003 -> valid_o stays 0; setting mask_i to all ones -> id_o=0 offered next edge.
REQ-034: Exercise both clear_i=1 and rst_n=0 asserted mid-offer with 5 bits pending -> next state pending_q=0, valid_o=0, count_o=0, and same-cycle req_i ignored.
